// File: rtl/pipelined_control_unit.sv
// MIPS control unit: decodes the ID-stage instruction and carries its control bundle through
// ID/EX, EX/MEM and MEM/WB, handling load-use stalls, taken-branch and jump flushes.
module pipelined_control_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 4,
  parameter int unsigned LOAD_STALL = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [5:0]            Opcode,
  input  logic [5:0]            FuncCode,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic [REG_ADDR_W-1:0] ID_Rd,
  input  logic                  EX_Zero,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  BranchTaken,
  output logic                  ID_Jump,
  output logic                  ID_Jr,
  output logic                  ID_SignExtend,
  output logic [ALUOP_W-1:0]    EX_ALUOp,
  output logic                  EX_ALUSrcImm,
  output logic [REG_ADDR_W-1:0] EX_DestReg,
  output logic                  EX_MemRead,
  output logic                  MEM_MemRead,
  output logic                  MEM_MemWrite,
  output logic                  MEM_RegWrite,
  output logic [REG_ADDR_W-1:0] MEM_DestReg,
  output logic                  WB_RegWrite,
  output logic                  WB_MemToReg,
  output logic                  WB_Jal,
  output logic [REG_ADDR_W-1:0] WB_DestReg,
  output logic                  IllegalOp
);

  localparam logic [5:0] OpRtype = 6'd0;
  localparam logic [5:0] OpJ     = 6'd2;
  localparam logic [5:0] OpJal   = 6'd3;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpAddi  = 6'd8;
  localparam logic [5:0] OpAddiu = 6'd9;
  localparam logic [5:0] OpSlti  = 6'd10;
  localparam logic [5:0] OpSltiu = 6'd11;
  localparam logic [5:0] OpAndi  = 6'd12;
  localparam logic [5:0] OpOri   = 6'd13;
  localparam logic [5:0] OpXori  = 6'd14;
  localparam logic [5:0] OpLui   = 6'd15;
  localparam logic [5:0] OpLw    = 6'd35;
  localparam logic [5:0] OpSw    = 6'd43;
  localparam logic [5:0] FnJr    = 6'd8;

  localparam logic [ALUOP_W-1:0] AluAnd  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluOr   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluAdd  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AluSub  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] AluSlt  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] AluAddu = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] AluXor  = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] AluSltu = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] AluLui  = ALUOP_W'(14);
  localparam logic [ALUOP_W-1:0] AluRtyp = ALUOP_W'(15);

  localparam int unsigned CntW = 2;
  localparam logic [CntW-1:0] StallLoad = CntW'(LOAD_STALL - 1);
  localparam logic [REG_ADDR_W-1:0] RegRa = REG_ADDR_W'(31);

  // ID-stage decode
  logic [ALUOP_W-1:0]    dec_alu_op;
  logic [REG_ADDR_W-1:0] dec_dest;
  logic dec_alu_src_imm, dec_sign_ext, dec_mem_read, dec_mem_write, dec_reg_write;
  logic dec_mem_to_reg, dec_jal, dec_jump, dec_jr, dec_branch, dec_reads_rt, dec_illegal;

  always_comb begin
    dec_alu_op      = '0;
    dec_dest        = ID_Rt;
    dec_alu_src_imm = 1'b0;
    dec_sign_ext    = 1'b0;
    dec_mem_read    = 1'b0;
    dec_mem_write   = 1'b0;
    dec_reg_write   = 1'b0;
    dec_mem_to_reg  = 1'b0;
    dec_jal         = 1'b0;
    dec_jump        = 1'b0;
    dec_jr          = 1'b0;
    dec_branch      = 1'b0;
    dec_reads_rt    = 1'b0;
    dec_illegal     = 1'b0;
    case (Opcode)
      OpRtype: begin
        dec_alu_op    = AluRtyp;
        dec_dest      = ID_Rd;
        dec_reads_rt  = 1'b1;
        dec_jr        = (FuncCode == FnJr);
        dec_reg_write = (FuncCode != FnJr);
      end
      OpJ: dec_jump = 1'b1;
      OpJal: begin
        dec_jump      = 1'b1;
        dec_jal       = 1'b1;
        dec_reg_write = 1'b1;
        dec_dest      = RegRa;
      end
      OpBeq: begin
        dec_alu_op   = AluSub;
        dec_sign_ext = 1'b1;
        dec_branch   = 1'b1;
        dec_reads_rt = 1'b1;
      end
      OpLw: begin
        dec_alu_op      = AluAdd;
        dec_alu_src_imm = 1'b1;
        dec_sign_ext    = 1'b1;
        dec_mem_read    = 1'b1;
        dec_mem_to_reg  = 1'b1;
        dec_reg_write   = 1'b1;
      end
      OpSw: begin
        dec_alu_op      = AluAdd;
        dec_alu_src_imm = 1'b1;
        dec_sign_ext    = 1'b1;
        dec_mem_write   = 1'b1;
        dec_reads_rt    = 1'b1;
      end
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: begin
        dec_alu_src_imm = 1'b1;
        dec_reg_write   = 1'b1;
        dec_sign_ext    = (Opcode == OpAddi) || (Opcode == OpAddiu) ||
                          (Opcode == OpSlti) || (Opcode == OpSltiu);
        case (Opcode)
          OpAddi:  dec_alu_op = AluAdd;
          OpAddiu: dec_alu_op = AluAddu;
          OpSlti:  dec_alu_op = AluSlt;
          OpSltiu: dec_alu_op = AluSltu;
          OpAndi:  dec_alu_op = AluAnd;
          OpOri:   dec_alu_op = AluOr;
          OpXori:  dec_alu_op = AluXor;
          default: dec_alu_op = AluLui;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Pipeline state
  logic [ALUOP_W-1:0]    ex_alu_op_q, ex_alu_op_d;
  logic [REG_ADDR_W-1:0] ex_dest_q, ex_dest_d;
  logic ex_alu_src_imm_q, ex_alu_src_imm_d, ex_mem_read_q, ex_mem_read_d;
  logic ex_mem_write_q, ex_mem_write_d, ex_reg_write_q, ex_reg_write_d;
  logic ex_mem_to_reg_q, ex_mem_to_reg_d, ex_jal_q, ex_jal_d, ex_branch_q, ex_branch_d;
  logic [REG_ADDR_W-1:0] mem_dest_q, wb_dest_q;
  logic mem_mem_read_q, mem_mem_write_q, mem_reg_write_q, mem_mem_to_reg_q, mem_jal_q;
  logic wb_reg_write_q, wb_mem_to_reg_q, wb_jal_q;
  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
  logic illegal_q, illegal_d;

  logic branch_taken, hazard_match, detect, stall, id_ex_bubble;

  always_comb begin
    branch_taken = ex_branch_q & EX_Zero;
    hazard_match = (ex_dest_q == ID_Rs) || (dec_reads_rt && (ex_dest_q == ID_Rt));
    detect       = ex_mem_read_q && (ex_dest_q != '0) && hazard_match && (stall_cnt_q == '0);
    // A taken branch squashes whatever sits in ID, so a pending stall is moot.
    stall        = (detect || (stall_cnt_q != '0)) && !branch_taken;
    id_ex_bubble = stall || branch_taken;

    if (branch_taken)            stall_cnt_d = '0;
    else if (detect)             stall_cnt_d = StallLoad;
    else if (stall_cnt_q != '0)  stall_cnt_d = stall_cnt_q - 1'b1;
    else                         stall_cnt_d = '0;

    illegal_d = illegal_q | (dec_illegal & ~id_ex_bubble);

    ex_alu_op_d      = id_ex_bubble ? '0 : dec_alu_op;
    ex_dest_d        = id_ex_bubble ? '0 : dec_dest;
    ex_alu_src_imm_d = dec_alu_src_imm & ~id_ex_bubble;
    ex_mem_read_d    = dec_mem_read    & ~id_ex_bubble;
    ex_mem_write_d   = dec_mem_write   & ~id_ex_bubble;
    ex_reg_write_d   = dec_reg_write   & ~id_ex_bubble;
    ex_mem_to_reg_d  = dec_mem_to_reg  & ~id_ex_bubble;
    ex_jal_d         = dec_jal         & ~id_ex_bubble;
    ex_branch_d      = dec_branch      & ~id_ex_bubble;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ex_alu_op_q      <= '0;
      ex_dest_q        <= '0;
      ex_alu_src_imm_q <= 1'b0;
      ex_mem_read_q    <= 1'b0;
      ex_mem_write_q   <= 1'b0;
      ex_reg_write_q   <= 1'b0;
      ex_mem_to_reg_q  <= 1'b0;
      ex_jal_q         <= 1'b0;
      ex_branch_q      <= 1'b0;
      mem_dest_q       <= '0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_jal_q        <= 1'b0;
      wb_dest_q        <= '0;
      wb_reg_write_q   <= 1'b0;
      wb_mem_to_reg_q  <= 1'b0;
      wb_jal_q         <= 1'b0;
      stall_cnt_q      <= '0;
      illegal_q        <= 1'b0;
    end else begin
      ex_alu_op_q      <= ex_alu_op_d;
      ex_dest_q        <= ex_dest_d;
      ex_alu_src_imm_q <= ex_alu_src_imm_d;
      ex_mem_read_q    <= ex_mem_read_d;
      ex_mem_write_q   <= ex_mem_write_d;
      ex_reg_write_q   <= ex_reg_write_d;
      ex_mem_to_reg_q  <= ex_mem_to_reg_d;
      ex_jal_q         <= ex_jal_d;
      ex_branch_q      <= ex_branch_d;
      mem_dest_q       <= ex_dest_q;
      mem_mem_read_q   <= ex_mem_read_q;
      mem_mem_write_q  <= ex_mem_write_q;
      mem_reg_write_q  <= ex_reg_write_q;
      mem_mem_to_reg_q <= ex_mem_to_reg_q;
      mem_jal_q        <= ex_jal_q;
      wb_dest_q        <= mem_dest_q;
      wb_reg_write_q   <= mem_reg_write_q;
      wb_mem_to_reg_q  <= mem_mem_to_reg_q;
      wb_jal_q         <= mem_jal_q;
      stall_cnt_q      <= stall_cnt_d;
      illegal_q        <= illegal_d;
    end
  end

  always_comb begin
    PCWrite       = Reset | ~stall;
    IF_ID_Write   = Reset | ~stall;
    BranchTaken   = ~Reset & branch_taken;
    ID_Jump       = dec_jump & ~id_ex_bubble;
    ID_Jr         = dec_jr & ~id_ex_bubble;
    IF_ID_Flush   = ~Reset & (branch_taken | ((dec_jump | dec_jr) & ~stall));
    ID_SignExtend = dec_sign_ext;
    EX_ALUOp      = ex_alu_op_q;
    EX_ALUSrcImm  = ex_alu_src_imm_q;
    EX_DestReg    = ex_dest_q;
    EX_MemRead    = ex_mem_read_q;
    MEM_MemRead   = mem_mem_read_q;
    MEM_MemWrite  = mem_mem_write_q;
    MEM_RegWrite  = mem_reg_write_q;
    MEM_DestReg   = mem_dest_q;
    WB_RegWrite   = wb_reg_write_q;
    WB_MemToReg   = wb_mem_to_reg_q;
    WB_Jal        = wb_jal_q;
    WB_DestReg    = wb_dest_q;
    IllegalOp     = illegal_q;
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench: two instances (LOAD_STALL = 1 and 3) share one instruction stream.
module tb_pipelined_control_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] Opcode, FuncCode;
  logic [4:0] ID_Rs, ID_Rt, ID_Rd;
  logic       EX_Zero;

  logic       a_PCWrite, a_IF_ID_Write, a_IF_ID_Flush, a_BranchTaken, a_ID_Jump, a_ID_Jr;
  logic       a_ID_SignExtend, a_EX_ALUSrcImm, a_EX_MemRead, a_MEM_MemRead, a_MEM_MemWrite;
  logic       a_MEM_RegWrite, a_WB_RegWrite, a_WB_MemToReg, a_WB_Jal, a_IllegalOp;
  logic [3:0] a_EX_ALUOp;
  logic [4:0] a_EX_DestReg, a_MEM_DestReg, a_WB_DestReg;

  logic       c_PCWrite, c_IF_ID_Write, c_IF_ID_Flush, c_BranchTaken, c_ID_Jump, c_ID_Jr;
  logic       c_ID_SignExtend, c_EX_ALUSrcImm, c_EX_MemRead, c_MEM_MemRead, c_MEM_MemWrite;
  logic       c_MEM_RegWrite, c_WB_RegWrite, c_WB_MemToReg, c_WB_Jal, c_IllegalOp;
  logic [3:0] c_EX_ALUOp;
  logic [4:0] c_EX_DestReg, c_MEM_DestReg, c_WB_DestReg;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  pipelined_control_unit #(.REG_ADDR_W(5), .ALUOP_W(4), .LOAD_STALL(1)) dut_a (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .FuncCode(FuncCode), .ID_Rs(ID_Rs),
    .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .EX_Zero(EX_Zero), .PCWrite(a_PCWrite),
    .IF_ID_Write(a_IF_ID_Write), .IF_ID_Flush(a_IF_ID_Flush), .BranchTaken(a_BranchTaken),
    .ID_Jump(a_ID_Jump), .ID_Jr(a_ID_Jr), .ID_SignExtend(a_ID_SignExtend),
    .EX_ALUOp(a_EX_ALUOp), .EX_ALUSrcImm(a_EX_ALUSrcImm), .EX_DestReg(a_EX_DestReg),
    .EX_MemRead(a_EX_MemRead), .MEM_MemRead(a_MEM_MemRead), .MEM_MemWrite(a_MEM_MemWrite),
    .MEM_RegWrite(a_MEM_RegWrite), .MEM_DestReg(a_MEM_DestReg), .WB_RegWrite(a_WB_RegWrite),
    .WB_MemToReg(a_WB_MemToReg), .WB_Jal(a_WB_Jal), .WB_DestReg(a_WB_DestReg),
    .IllegalOp(a_IllegalOp)
  );

  pipelined_control_unit #(.REG_ADDR_W(5), .ALUOP_W(4), .LOAD_STALL(3)) dut_c (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .FuncCode(FuncCode), .ID_Rs(ID_Rs),
    .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .EX_Zero(EX_Zero), .PCWrite(c_PCWrite),
    .IF_ID_Write(c_IF_ID_Write), .IF_ID_Flush(c_IF_ID_Flush), .BranchTaken(c_BranchTaken),
    .ID_Jump(c_ID_Jump), .ID_Jr(c_ID_Jr), .ID_SignExtend(c_ID_SignExtend),
    .EX_ALUOp(c_EX_ALUOp), .EX_ALUSrcImm(c_EX_ALUSrcImm), .EX_DestReg(c_EX_DestReg),
    .EX_MemRead(c_EX_MemRead), .MEM_MemRead(c_MEM_MemRead), .MEM_MemWrite(c_MEM_MemWrite),
    .MEM_RegWrite(c_MEM_RegWrite), .MEM_DestReg(c_MEM_DestReg), .WB_RegWrite(c_WB_RegWrite),
    .WB_MemToReg(c_WB_MemToReg), .WB_Jal(c_WB_Jal), .WB_DestReg(c_WB_DestReg),
    .IllegalOp(c_IllegalOp)
  );

  task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
    Opcode = op; FuncCode = fn; ID_Rs = rs; ID_Rt = rt; ID_Rd = rd;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic drain;
    set_id(6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    EX_Zero = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    EX_Zero = 1'b0;
    set_id(6'd3, 6'd0, 5'd0, 5'd0, 5'd0);
    @(negedge Clk);
    checks++; if (a_PCWrite !== 1'b1) begin failures++;
      $display("FAIL rst_pcwrite got=%b exp=1", a_PCWrite); end
    checks++; if (a_IF_ID_Write !== 1'b1) begin failures++;
      $display("FAIL rst_ifid_write got=%b exp=1", a_IF_ID_Write); end
    checks++; if (a_IF_ID_Flush !== 1'b0) begin failures++;
      $display("FAIL rst_flush got=%b exp=0", a_IF_ID_Flush); end
    checks++; if (a_EX_DestReg !== 5'd0 || a_WB_RegWrite !== 1'b0 || a_IllegalOp !== 1'b0) begin
      failures++; $display("FAIL rst_state got ex_dest=%0d wb_rw=%b ill=%b exp 0/0/0",
                           a_EX_DestReg, a_WB_RegWrite, a_IllegalOp); end
    set_id(6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    Reset = 1'b0;
    drain();
  endtask

  task automatic test_load_use;
    int a_stalls = 0;
    int c_stalls = 0;
    set_id(6'd35, 6'd0, 5'd2, 5'd8, 5'd0);   // lw $8, 0($2)
    @(negedge Clk);
    checks++; if (a_PCWrite !== 1'b1) begin failures++;
      $display("FAIL lu_no_early_stall got=%b exp=1", a_PCWrite); end
    tick();
    checks++; if (a_EX_MemRead !== 1'b1 || a_EX_DestReg !== 5'd8 || a_EX_ALUOp !== 4'd2) begin
      failures++; $display("FAIL lu_lw_in_ex got rd=%b dest=%0d op=%0d exp 1/8/2",
                           a_EX_MemRead, a_EX_DestReg, a_EX_ALUOp); end
    set_id(6'd0, 6'd32, 5'd8, 5'd3, 5'd9);   // add $9, $8, $3 held in ID
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (a_PCWrite === 1'b0) a_stalls++;
      if (c_PCWrite === 1'b0) c_stalls++;
      checks++; if (a_PCWrite !== (i != 0) || a_IF_ID_Write !== (i != 0)) begin failures++;
        $display("FAIL lu_stall1_cycle%0d got pcw=%b ifw=%b exp=%b", i, a_PCWrite,
                 a_IF_ID_Write, (i != 0)); end
      checks++; if (c_PCWrite !== (i >= 3)) begin failures++;
        $display("FAIL lu_stall3_cycle%0d got pcw=%b exp=%b", i, c_PCWrite, (i >= 3)); end
      tick();
      if (i == 0) begin
        checks++;
        if (a_EX_ALUOp !== 4'd0 || a_EX_DestReg !== 5'd0 || a_EX_MemRead !== 1'b0) begin
          failures++; $display("FAIL lu_bubble got op=%0d dest=%0d rd=%b exp 0/0/0",
                               a_EX_ALUOp, a_EX_DestReg, a_EX_MemRead); end
        checks++; if (a_MEM_MemRead !== 1'b1 || a_MEM_DestReg !== 5'd8) begin failures++;
          $display("FAIL lu_lw_in_mem got rd=%b dest=%0d exp 1/8", a_MEM_MemRead,
                   a_MEM_DestReg); end
      end
      if (i == 1) begin
        checks++; if (a_EX_ALUOp !== 4'd15 || a_EX_DestReg !== 5'd9) begin failures++;
          $display("FAIL lu_add_in_ex got op=%0d dest=%0d exp 15/9", a_EX_ALUOp,
                   a_EX_DestReg); end
        checks++; if (a_WB_MemToReg !== 1'b1 || a_WB_DestReg !== 5'd8) begin failures++;
          $display("FAIL lu_lw_in_wb got m2r=%b dest=%0d exp 1/8", a_WB_MemToReg,
                   a_WB_DestReg); end
      end
      if (i == 2) begin
        checks++; if (c_EX_ALUOp !== 4'd0 || c_EX_DestReg !== 5'd0) begin failures++;
          $display("FAIL lu3_bubble got op=%0d dest=%0d exp 0/0", c_EX_ALUOp, c_EX_DestReg); end
      end
      if (i == 3) begin
        checks++; if (c_EX_ALUOp !== 4'd15 || c_EX_DestReg !== 5'd9) begin failures++;
          $display("FAIL lu3_add_in_ex got op=%0d dest=%0d exp 15/9", c_EX_ALUOp,
                   c_EX_DestReg); end
      end
    end
    checks++; if (a_stalls != 1 || c_stalls != 3) begin failures++;
      $display("FAIL lu_stall_counts got a=%0d c=%0d exp 1/3", a_stalls, c_stalls); end
    drain();
  endtask

  task automatic test_no_stall;
    set_id(6'd35, 6'd0, 5'd2, 5'd0, 5'd0);   // lw $0
    tick();
    set_id(6'd0, 6'd32, 5'd0, 5'd3, 5'd9);   // add $9, $0, $3
    @(negedge Clk);
    checks++; if (a_PCWrite !== 1'b1 || c_PCWrite !== 1'b1) begin failures++;
      $display("FAIL ns_lw_r0 got a=%b c=%b exp 1/1", a_PCWrite, c_PCWrite); end
    tick();
    set_id(6'd35, 6'd0, 5'd2, 5'd8, 5'd0);   // lw $8
    tick();
    set_id(6'd13, 6'd0, 5'd3, 5'd8, 5'd0);   // ori $8, $3: rt not read
    @(negedge Clk);
    checks++; if (a_PCWrite !== 1'b1 || c_PCWrite !== 1'b1) begin failures++;
      $display("FAIL ns_ori_rt got a=%b c=%b exp 1/1", a_PCWrite, c_PCWrite); end
    checks++; if (a_ID_SignExtend !== 1'b0) begin failures++;
      $display("FAIL ns_ori_zext got=%b exp=0", a_ID_SignExtend); end
    tick();
    checks++; if (a_EX_ALUOp !== 4'd1 || a_EX_ALUSrcImm !== 1'b1 || a_EX_DestReg !== 5'd8) begin
      failures++; $display("FAIL ns_ori_ex got op=%0d imm=%b dest=%0d exp 1/1/8",
                           a_EX_ALUOp, a_EX_ALUSrcImm, a_EX_DestReg); end
    set_id(6'd35, 6'd0, 5'd2, 5'd8, 5'd0);   // lw $8
    tick();
    set_id(6'd43, 6'd0, 5'd3, 5'd8, 5'd0);   // sw $8: reads rt
    @(negedge Clk);
    checks++; if (a_PCWrite !== 1'b0) begin failures++;
      $display("FAIL ns_sw_rt_stall got=%b exp=0", a_PCWrite); end
    drain();
  endtask

  task automatic test_branch;
    set_id(6'd4, 6'd0, 5'd1, 5'd2, 5'd0);    // beq
    tick();
    checks++; if (a_EX_ALUOp !== 4'd6 || a_EX_ALUSrcImm !== 1'b0) begin failures++;
      $display("FAIL br_beq_ex got op=%0d imm=%b exp 6/0", a_EX_ALUOp, a_EX_ALUSrcImm); end
    set_id(6'd8, 6'd0, 5'd1, 5'd5, 5'd0);    // addi $5
    EX_Zero = 1'b1;
    @(negedge Clk);
    checks++; if (a_BranchTaken !== 1'b1 || a_IF_ID_Flush !== 1'b1 || a_PCWrite !== 1'b1) begin
      failures++; $display("FAIL br_taken got bt=%b fl=%b pcw=%b exp 1/1/1",
                           a_BranchTaken, a_IF_ID_Flush, a_PCWrite); end
    tick();
    EX_Zero = 1'b0;
    checks++; if (a_EX_ALUOp !== 4'd0 || a_EX_DestReg !== 5'd0) begin failures++;
      $display("FAIL br_taken_bubble got op=%0d dest=%0d exp 0/0", a_EX_ALUOp,
               a_EX_DestReg); end
    set_id(6'd4, 6'd0, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(6'd8, 6'd0, 5'd1, 5'd5, 5'd0);
    @(negedge Clk);
    checks++; if (a_BranchTaken !== 1'b0 || a_IF_ID_Flush !== 1'b0) begin failures++;
      $display("FAIL br_not_taken got bt=%b fl=%b exp 0/0", a_BranchTaken, a_IF_ID_Flush); end
    tick();
    checks++; if (a_EX_ALUOp !== 4'd2 || a_EX_DestReg !== 5'd5) begin failures++;
      $display("FAIL br_not_taken_ex got op=%0d dest=%0d exp 2/5", a_EX_ALUOp,
               a_EX_DestReg); end
    set_id(6'd4, 6'd0, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(6'd3, 6'd0, 5'd0, 5'd0, 5'd0);    // jal while branch resolves taken
    EX_Zero = 1'b1;
    @(negedge Clk);
    checks++; if (a_ID_Jump !== 1'b0 || a_IF_ID_Flush !== 1'b1 || a_BranchTaken !== 1'b1) begin
      failures++; $display("FAIL br_vs_jal got jmp=%b fl=%b bt=%b exp 0/1/1",
                           a_ID_Jump, a_IF_ID_Flush, a_BranchTaken); end
    tick();
    EX_Zero = 1'b0;
    checks++; if (a_EX_DestReg !== 5'd0) begin failures++;
      $display("FAIL br_vs_jal_squash got dest=%0d exp=0", a_EX_DestReg); end
    set_id(6'd4, 6'd0, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(6'd63, 6'd0, 5'd0, 5'd0, 5'd0);   // flushed illegal op
    EX_Zero = 1'b1;
    tick();
    EX_Zero = 1'b0;
    checks++; if (a_IllegalOp !== 1'b0) begin failures++;
      $display("FAIL br_flushed_illegal got=%b exp=0", a_IllegalOp); end
    drain();
  endtask

  task automatic test_jal;
    set_id(6'd3, 6'd0, 5'd0, 5'd0, 5'd0);
    @(negedge Clk);
    checks++; if (a_IF_ID_Flush !== 1'b1 || a_ID_Jump !== 1'b1) begin failures++;
      $display("FAIL jal_flush got fl=%b jmp=%b exp 1/1", a_IF_ID_Flush, a_ID_Jump); end
    tick();
    checks++; if (a_EX_DestReg !== 5'd31) begin failures++;
      $display("FAIL jal_ex_dest got=%0d exp=31", a_EX_DestReg); end
    set_id(6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    checks++; if (a_WB_Jal !== 1'b1 || a_WB_RegWrite !== 1'b1 || a_WB_DestReg !== 5'd31) begin
      failures++; $display("FAIL jal_wb got jal=%b rw=%b dest=%0d exp 1/1/31",
                           a_WB_Jal, a_WB_RegWrite, a_WB_DestReg); end
    set_id(6'd0, 6'd8, 5'd31, 5'd0, 5'd0);   // jr $31
    @(negedge Clk);
    checks++; if (a_ID_Jr !== 1'b1 || a_IF_ID_Flush !== 1'b1) begin failures++;
      $display("FAIL jr_flush got jr=%b fl=%b exp 1/1", a_ID_Jr, a_IF_ID_Flush); end
    drain();
  endtask

  task automatic test_illegal;
    set_id(6'd63, 6'd0, 5'd0, 5'd4, 5'd0);
    @(negedge Clk);
    checks++; if (a_IllegalOp !== 1'b0) begin failures++;
      $display("FAIL ill_pre got=%b exp=0", a_IllegalOp); end
    tick();
    checks++; if (a_IllegalOp !== 1'b1) begin failures++;
      $display("FAIL ill_set got=%b exp=1", a_IllegalOp); end
    set_id(6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    checks++; if (a_MEM_MemWrite !== 1'b0 || a_MEM_RegWrite !== 1'b0) begin failures++;
      $display("FAIL ill_mem got mw=%b rw=%b exp 0/0", a_MEM_MemWrite, a_MEM_RegWrite); end
    tick();
    checks++; if (a_WB_RegWrite !== 1'b0) begin failures++;
      $display("FAIL ill_wb got rw=%b exp=0", a_WB_RegWrite); end
    repeat (3) tick();
    checks++; if (a_IllegalOp !== 1'b1) begin failures++;
      $display("FAIL ill_sticky got=%b exp=1", a_IllegalOp); end
  endtask

  task automatic test_reset_midstream;
    set_id(6'd35, 6'd0, 5'd2, 5'd8, 5'd0);
    tick();
    set_id(6'd35, 6'd0, 5'd2, 5'd7, 5'd0);
    tick();
    checks++; if (a_MEM_MemRead !== 1'b1) begin failures++;
      $display("FAIL rm_pre_mem got=%b exp=1", a_MEM_MemRead); end
    Reset = 1'b1;
    #1;
    checks++;
    if (a_MEM_MemRead !== 1'b0 || a_MEM_DestReg !== 5'd0 || a_EX_MemRead !== 1'b0 ||
        a_EX_DestReg !== 5'd0 || a_WB_RegWrite !== 1'b0 || a_IllegalOp !== 1'b0) begin
      failures++; $display("FAIL rm_async got mrd=%b md=%0d erd=%b ed=%0d wrw=%b ill=%b exp 0",
                           a_MEM_MemRead, a_MEM_DestReg, a_EX_MemRead, a_EX_DestReg,
                           a_WB_RegWrite, a_IllegalOp); end
    tick();
    checks++; if (a_MEM_MemRead !== 1'b0 || a_WB_MemToReg !== 1'b0 || a_PCWrite !== 1'b1) begin
      failures++; $display("FAIL rm_next got mrd=%b m2r=%b pcw=%b exp 0/0/1",
                           a_MEM_MemRead, a_WB_MemToReg, a_PCWrite); end
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_jal();
    test_illegal();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Successor to the single-stage MIPS control decoder.
- Decodes the ID-stage instruction and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts a parametrised stall count, and flushes on jumps and taken branches.
- Sits between the IF/ID register and the datapath. The datapath consumes only this block's stage-qualified outputs.

Parameters:
- REG_ADDR_W, 5, register address width.
- ALUOP_W, 4, ALU operation code width. ALU encodings are unchanged: AND 0, OR 1, ADD 2, SUB 6, SLT 7, ADDU 8, XOR 10, SLTU 11, LUI 14, RTYP 15.
- LOAD_STALL, 1, bubbles inserted per load-use hazard (1..3).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Opcode  in  6  ID instruction [31:26].
- FuncCode  in  6  ID instruction [5:0].
- ID_Rs  in  REG_ADDR_W  ID rs field.
- ID_Rt  in  REG_ADDR_W  ID rt field.
- ID_Rd  in  REG_ADDR_W  ID rd field.
- EX_Zero  in  1  ALU zero flag for the instruction in EX.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  clear IF/ID to NOP.
- BranchTaken  out  1  select branch target for the PC.
- ID_Jump  out  1  J/JAL in ID, stall-qualified.
- ID_Jr  out  1  JR in ID, stall-qualified.
- ID_SignExtend  out  1  immediate extension mode.
- EX_ALUOp  out  ALUOP_W  ALU operation.
- EX_ALUSrcImm  out  1  second ALU operand is the immediate.
- EX_DestReg  out  REG_ADDR_W  resolved destination (rt, rd or 31).
- EX_MemRead  out  1  EX-stage load flag.
- MEM_MemRead  out  1  data memory read.
- MEM_MemWrite  out  1  data memory write.
- MEM_RegWrite  out  1  write-back pending (forwarding use).
- MEM_DestReg  out  REG_ADDR_W  destination register.
- WB_RegWrite  out  1  register file write enable.
- WB_MemToReg  out  1  write-back source is memory.
- WB_Jal  out  1  write-back data is PC+8.
- WB_DestReg  out  REG_ADDR_W  destination register.
- IllegalOp  out  1  sticky unknown-opcode flag.

Behaviour:
- Decode (combinational, ID stage). Supported instructions: R-type, LW, SW, BEQ, J, JAL, ORI, ADDI, ADDIU, ANDI, LUI, SLTI, SLTIU, XORI.
- Signal values per class are unchanged from the previous decoder:
  - JAL: DestReg = 31.
  - R-type: DestReg = rd.
  - Everything else: DestReg = rt.
  - ALUSrcImm = 1 for loads, stores and all I-type ALU ops; 0 for R-type and BEQ.
  - Unknown opcode: all write and enable controls 0.
- Pipeline registers. The ID/EX, EX/MEM and MEM/WB control registers and the DestReg fields advance every cycle with no global enable.
- Reset (asynchronous, immediate). All stage registers, the stall counter and IllegalOp go to 0. While reset is held: PCWrite = 1, IF_ID_Write = 1, IF_ID_Flush = 0, BranchTaken = 0.
- Load-use detect:
  - Fires when EX_MemRead = 1 and EX_DestReg != 0.
  - Rs match: EX_DestReg == ID_Rs.
  - Rt match: EX_DestReg == ID_Rt, counted only when the ID instruction reads rt (R-type, SW, BEQ).
  - A detect fires only when the stall counter is 0.
- Stall:
  - On detect, the stall counter loads LOAD_STALL-1.
  - Stall is asserted in the detect cycle and in every cycle the counter is nonzero. The counter decrements each stall cycle.
  - While stalled: PCWrite = 0, IF_ID_Write = 0, and the ID/EX control register is loaded with a bubble (all enables 0, DestReg 0).
  - ID_Jump and ID_Jr are forced to 0.
- Branch: BranchTaken = EX_Branch & EX_Zero.
  - When taken: IF_ID_Flush = 1, the ID/EX register loads a bubble, and PCWrite = 1.
  - The stall counter clears to 0. A taken branch overrides stall in the same cycle.
- Jump: ID_Jump or ID_Jr set and not stalled gives IF_ID_Flush = 1. The jump instruction itself proceeds to EX (JAL needs write-back).
- Simultaneous events: a taken branch in EX and a jump in ID in the same cycle: the branch wins and the jump is squashed as a bubble.
- IllegalOp: set on the edge where an unknown opcode enters ID/EX (not when it arrives as a bubble or is flushed). Cleared only by Reset.
- Latency: control reaches EX 1 cycle after ID, MEM after 2, WB after 3.

Test Plan:
- Reset mid-stream (Reset = 1 while a LW is in MEM) -> next cycle all MEM_*, WB_* and EX_* outputs are 0 and PCWrite = 1.
- LW $8 then ADD $9,$8,$3, LOAD_STALL=1 -> one cycle with PCWrite=0 and IF_ID_Write=0; EX shows a bubble; ADD reaches EX one cycle late with EX_ALUOp=15 and EX_DestReg=9.
- Same sequence with LOAD_STALL=3 -> exactly 3 consecutive stall cycles. Repeat with LW $0 -> no stall.
- BEQ in EX with EX_Zero=1 -> BranchTaken=1, IF_ID_Flush=1, next EX_ALUOp=0 and EX_DestReg=0. With EX_Zero=0 -> no flush.
- JAL in ID -> IF_ID_Flush=1 that cycle; 3 cycles later WB_Jal=1, WB_RegWrite=1, WB_DestReg=31.
- Opcode 6'b111111 -> IllegalOp=1 one edge later and stays high; WB_RegWrite and MEM_MemWrite stay 0 for that instruction.
